// File: rtl/buffer_ram_slot_if.sv
// Request bundle from the interconnect into a buffer RAM slot.
interface buffer_ram_slot_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       raddr;
  logic [31:0]       waddr;
  logic [DATA_W-1:0] wdata;
  logic              wren;

  modport master (output raddr, output waddr, output wdata, output wren);
  modport slave  (input  raddr, input  waddr, input  wdata, input  wren);
endinterface

// File: rtl/buffer_ram_slot.sv
// Slot RAM with a zero-fill sweep, dropped-write counter and fixed CYCLES read latency.
// Define BUFFER_RAM_BYPASS_EN to forward same-cycle same-address write data to the read.
//
// state | meaning
// CLEAR | zero-fill sweep, one word per cycle; writes ignored, reads return 0
// RUN   | normal read/write service
module buffer_ram_slot #(
  parameter int DEPTH  = 1024,
  parameter int CYCLES = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  buffer_ram_slot_if.slave  ram_in,
  output logic [DATA_W-1:0] ram_out,
  input  logic              clear_req,
  output logic              busy,
  output logic [15:0]       drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pipe_q [CYCLES];
  logic [DATA_W-1:0] rd_word;
  logic              waddr_ok, raddr_ok;
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              drop_inc;

  assign waddr_ok = ram_in.waddr < 32'(DEPTH);
  assign raddr_ok = ram_in.raddr < 32'(DEPTH);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy       = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = ram_in.waddr[AW-1:0];
    mem_wd     = ram_in.wdata;
    drop_inc   = 1'b0;
    case (state_q)
      CLEAR: begin
        busy       = 1'b1;
        mem_we     = 1'b1;
        mem_wa     = clr_addr_q;
        mem_wd     = '0;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == AW'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        if (ram_in.wren) begin
          if (waddr_ok) mem_we = 1'b1;
          else if (drop_cnt != 16'hFFFF) drop_inc = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
    // A clear request always (re)starts the sweep, even on its last cycle.
    if (clear_req) begin
      state_d    = CLEAR;
      clr_addr_d = '0;
    end
  end

  always_comb begin
    rd_word = '0;
    if (state_q == RUN && raddr_ok) begin
`ifdef BUFFER_RAM_BYPASS_EN
      if (ram_in.wren && waddr_ok && (ram_in.waddr == ram_in.raddr)) rd_word = ram_in.wdata;
      else rd_word = mem[ram_in.raddr[AW-1:0]];
`else
      rd_word = mem[ram_in.raddr[AW-1:0]];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      drop_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      if (drop_inc) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn && mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < CYCLES; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= rd_word;
      for (int i = 1; i < CYCLES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign ram_out = pipe_q[CYCLES-1];
endmodule

// File: tb/tb_buffer_ram_slot.sv
// Directed bench for buffer_ram_slot (DEPTH=16, CYCLES=2) with a per-cycle reference model.
module tb_buffer_ram_slot;
  localparam int DEPTH = 16;
  localparam int CYC   = 2;
  localparam int DW    = 8;
`ifdef BUFFER_RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          clear_req = 1'b0;
  logic          busy;
  logic [DW-1:0] ram_out;
  logic [15:0]   drop_cnt;
  int            checks = 0;
  int            failures = 0;

  buffer_ram_slot_if #(.DATA_W(DW)) bus ();

  buffer_ram_slot #(.DEPTH(DEPTH), .CYCLES(CYC), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn), .ram_in(bus), .ram_out(ram_out),
    .clear_req(clear_req), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: whole-RAM zeroing at sweep start, a remaining-busy count,
  // and a FIFO of read results delayed by CYC edges.
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] rd_q [$];
  int            clear_left = 0;
  int            drop_m = 0;
  bit            model_valid = 1'b0;

  always @(posedge clk) begin
    logic [DW-1:0] r;
    bit in_clear;
    if (rstn) begin
      model_valid = 1'b1;
      clear_left  = DEPTH;
      drop_m      = 0;
      rd_q.delete();
      repeat (CYC) rd_q.push_back('0);
      foreach (mem_m[i]) mem_m[i] = '0;
    end else if (model_valid) begin
      in_clear = clear_left > 0;
      if (in_clear || bus.raddr >= DEPTH) r = '0;
      else if (BYP && bus.wren && bus.waddr == bus.raddr) r = bus.wdata;
      else r = mem_m[bus.raddr[3:0]];
      rd_q.push_back(r);
      void'(rd_q.pop_front());
      if (!in_clear && bus.wren) begin
        if (bus.waddr < DEPTH) mem_m[bus.waddr[3:0]] = bus.wdata;
        else if (drop_m < 65535) drop_m++;
      end
      if (clear_req) begin
        clear_left = DEPTH;
        foreach (mem_m[i]) mem_m[i] = '0;
      end else if (in_clear) begin
        clear_left--;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("busy", {31'b0, busy}, 32'(clear_left > 0));
      chk("drop_cnt", {16'b0, drop_cnt}, 32'(drop_m));
      chk("ram_out", {24'b0, ram_out}, {24'b0, rd_q[0]});
    end
  end

  task automatic cyc(input logic [31:0] ra, input logic [31:0] wa, input logic [DW-1:0] wd,
                     input logic we, input logic cr);
    bus.raddr = ra;
    bus.waddr = wa;
    bus.wdata = wd;
    bus.wren  = we;
    clear_req = cr;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(32'd0, 32'd0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    bus.raddr = '0; bus.waddr = '0; bus.wdata = '0; bus.wren = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      n++;
      idle();
    end
    chk("reset_busy_cycles", 32'(n), 32'd16);

    for (int a = 0; a < DEPTH; a++) cyc(32'(a), 32'd0, 8'h00, 1'b0, 1'b0);
    idle();
    idle();

    cyc(32'd0, 32'd3, 8'hA5, 1'b1, 1'b0);
    cyc(32'd0, 32'd4, 8'h44, 1'b1, 1'b0);
    cyc(32'd3, 32'd0, 8'h00, 1'b0, 1'b0);
    chk("rd_lat_early", {24'b0, ram_out}, 32'h0);
    idle();
    chk("rd_a5", {24'b0, ram_out}, 32'hA5);

    cyc(32'd4, 32'd7, 8'h77, 1'b1, 1'b0);
    idle();
    chk("rd_diff_addr", {24'b0, ram_out}, 32'h44);
    cyc(32'd7, 32'd0, 8'h00, 1'b0, 1'b0);
    idle();
    chk("rd_7", {24'b0, ram_out}, 32'h77);

    cyc(32'd0, 32'd5, 8'h11, 1'b1, 1'b0);
    cyc(32'd5, 32'd5, 8'h22, 1'b1, 1'b0);
    idle();
    chk("rdw_same_addr", {24'b0, ram_out}, BYP ? 32'h22 : 32'h11);
    cyc(32'd5, 32'd0, 8'h00, 1'b0, 1'b0);
    idle();
    chk("rdw_after", {24'b0, ram_out}, 32'h22);

    cyc(32'd0, 32'd16, 8'h5A, 1'b1, 1'b0);
    cyc(32'd0, 32'hFFFF_FFFF, 8'h6B, 1'b1, 1'b0);
    cyc(32'd20, 32'd0, 8'h00, 1'b0, 1'b0);
    idle();
    chk("drop_cnt_2", {16'b0, drop_cnt}, 32'd2);
    chk("rd_oob", {24'b0, ram_out}, 32'h0);
    cyc(32'd0, 32'd0, 8'h00, 1'b0, 1'b0);
    cyc(32'd15, 32'd0, 8'h00, 1'b0, 1'b0);
    chk("alias_0", {24'b0, ram_out}, 32'h0);
    idle();
    chk("alias_15", {24'b0, ram_out}, 32'h0);
    cyc(32'd0, 32'd100, 8'h01, 1'b1, 1'b0);
    chk("drop_cnt_3", {16'b0, drop_cnt}, 32'd3);

    cyc(32'd0, 32'd2, 8'h07, 1'b1, 1'b0);
    cyc(32'd2, 32'd0, 8'h00, 1'b0, 1'b0);
    idle();
    chk("rd_2_before", {24'b0, ram_out}, 32'h07);
    cyc(32'd0, 32'd0, 8'h00, 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) n++;
      cyc(32'd2, 32'd2, 8'h3C, 1'b1, 1'b0);
    end
    if (busy) n++;
    cyc(32'd2, 32'd40, 8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      n++;
      cyc(32'd2, (i % 2 == 1) ? 32'd40 : 32'd2, 8'h3C, 1'b1, 1'b0);
    end
    chk("restart_busy_cycles", 32'(n), 32'd21);
    chk("drop_unchanged", {16'b0, drop_cnt}, 32'd3);
    cyc(32'd2, 32'd0, 8'h00, 1'b0, 1'b0);
    idle();
    chk("rd_2_cleared", {24'b0, ram_out}, 32'h0);

    cyc(32'd0, 32'd0, 8'h00, 1'b0, 1'b1);
    idle();
    idle();
    idle();
    chk("drop_pre_rst", {16'b0, drop_cnt}, 32'd3);
    rstn = 1'b1;
    idle();
    rstn = 1'b0;
    chk("rst_drop_clr", {16'b0, drop_cnt}, 32'd0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      n++;
      idle();
    end
    chk("rst_busy_cycles", 32'(n), 32'd16);
    cyc(32'd3, 32'd0, 8'h00, 1'b0, 1'b0);
    idle();
    chk("rd_3_after_rst", {24'b0, ram_out}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
